axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
AXI4-Lite initiator that converts a simple single-command request interface into AXI4-Lite write (AW/W/B) or read (AR/R) transactions. It is the counterpart of the team's 4-register AXI4-Lite slave and drives it from bring-up sequencers, test controllers or a UART/JTAG bridge. One transaction is outstanding at a time. The result is returned on a held response interface.

Parameters:
ADDR_W, 4, AXI address width in bits.
DATA_W, 32, AXI data width in bits; only 32 is supported, so wstrb is 4 bits.

Ports:
aclk  in  1  clock; all logic is on the rising edge.
aresetn  in  1  synchronous, active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  byte address.
cmd_wdata  in  DATA_W  write data.
cmd_wstrb  in  DATA_W/8  write byte strobes.
rsp_valid  out  1  result available.
rsp_ready  in  1  result consumed.
rsp_write  out  1  copy of cmd_write for the completed command.
rsp_rdata  out  DATA_W  read data; 0 for writes.
rsp_resp  out  2  BRESP or RRESP value.
awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master-side directions and widths.
awprot, arprot  out  3  tied to 3'b000.

Behaviour:
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- Reset (aresetn=0 at a clock edge): state IDLE.
  - All valid/ready outputs are 0; rsp_resp, rsp_rdata and rsp_write are 0.
  - awaddr, araddr, wdata and wstrb are 0.
  - Reset mid-transaction abandons the transaction with no response issued.
- cmd_ready is 1 only in IDLE and is driven combinationally from state.
- On accept, the command is registered. The next cycle is WRITE or READ, with the valids already high (1-cycle issue latency).
- WRITE:
  - awvalid and wvalid rise together. awaddr, wdata and wstrb are driven from the registers.
  - Each valid drops the cycle after its own handshake. Flags aw_done and w_done track completion.
  - AW and W may complete in either order or in the same cycle.
  - Move to WRESP when both are done (including the same-cycle case).
  - Valids are never withdrawn before their handshake, and their payload is stable while valid.
- WRESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_rdata=0, go to RESP.
- READ: arvalid=1 until arready; then go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata and rresp, go to RESP.
- bready and rready are asserted only in WRESP and RDATA respectively, never speculatively.
- RESP:
  - rsp_valid=1 and the payload is held until rsp_ready, then return to IDLE.
  - A new command can be accepted at the earliest on the cycle after that IDLE entry; there is no bypass.
- Non-OKAY responses (SLVERR or DECERR) are forwarded unchanged. No retry.
- Minimum latency against a zero-wait slave:
  - Write: accept to rsp_valid = 3 cycles.
  - Read: accept to rsp_valid = 3 cycles.
- Address is passed through unaligned; alignment is the requester's responsibility.

Optional Feature:
AXIL_MST_ERR_CNT_EN
- Defined: adds output err_count[15:0].
  - Increments (saturating at 16'hFFFF) on each B or R handshake whose response is not 2'b00.
  - Cleared by reset.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package axi_lite_pkg holds:
  - Response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The state enum.
  - PROT_DEFAULT=3'b000.
- Single module; no sub-module. The AW/W dual-handshake tracker is too small to justify one.

Test Plan:
- Write then read:
  - Stimulus: write 0xDEADBEEF, wstrb 4'hF, address 0x4 to the team slave; then read 0x4.
  - Required: write rsp_resp=00; read rsp_rdata=0xDEADBEEF, rsp_resp=00.
  - Check all four registers at 0x0, 0x4, 0x8 and 0xC with distinct data.
- AW/W ordering: BFM slave delays awready by 3 cycles with wready immediate, then the reverse, then both in the same cycle -> exactly one AW and one W handshake per write, and wvalid deasserts the cycle after its handshake.
- Backpressure:
  - Stimulus: slave holds bvalid and rvalid off for 5 cycles; bench holds rsp_ready=0 for 4 cycles.
  - Required: bready and rready stay high while waiting, rsp payload is stable, and cmd_ready=0 until the cycle after the rsp handshake.
- Error path: BFM returns rresp=2'b10 -> rsp_resp=2'b10 is forwarded; with AXIL_MST_ERR_CNT_EN, err_count goes 0→1.
- Reset mid-write: deassert aresetn while awvalid=1 -> next edge all valids are 0, state is IDLE, no rsp_valid; a following read of 0x0 completes normally.
- Throughput: 100 back-to-back random commands against a zero-wait slave with rsp_ready=1 -> 4 cycles per command and a scoreboard match on every read.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Purpose : shared AXI4-Lite definitions (response codes, default prot, master FSM states).
// Latency : n/a (definitions only).
// Backpr. : n/a.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } axil_mst_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Purpose : single-outstanding AXI4-Lite initiator; one cmd in, AW/W/B or AR/R out, held rsp back.
// Latency : accept -> rsp_valid = 3 cycles with a zero-wait slave; 4 cycles per command back-to-back.
// Backpr. : cmd_ready only in IDLE; rsp held until rsp_ready; AXI valids held until their handshake.
// Option  : define AXIL_MST_ERR_CNT_EN to add the saturating err_count[15:0] output.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    // command request
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    // response
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    // write address
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    // write data
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    // write response
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    // read address
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    // read data
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
`ifdef AXIL_MST_ERR_CNT_EN
    ,
    output logic [15:0]         err_count
`endif
);

    axil_mst_state_t state_q, state_d;

    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done_q;
    logic                w_done_q;
    logic                rsp_write_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [1:0]          rsp_resp_q;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;

    // Payloads come straight from the command registers so they are stable while valid.
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign awprot    = PROT_DEFAULT;
    assign arprot    = PROT_DEFAULT;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                // A channel whose flag is clear has its valid up, so its ready alone
                // signals a handshake this cycle; covers AW/W landing together.
                if ((aw_done_q || awready) && (w_done_q || wready)) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d = RESP;
                end
            end
            READ: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command capture, AW/W completion flags and response capture.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            if (cmd_hs) begin
                write_q   <= cmd_write;
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end
            if (b_hs) begin
                rsp_write_q <= write_q;
                rsp_rdata_q <= '0;
                rsp_resp_q  <= bresp;
            end
            if (r_hs) begin
                rsp_write_q <= write_q;
                rsp_rdata_q <= rdata;
                rsp_resp_q  <= rresp;
            end
        end
    end

    // AR handshake only moves the FSM; nothing else to record.
    logic unused_ar_hs;
    assign unused_ar_hs = ar_hs;

`ifdef AXIL_MST_ERR_CNT_EN
    // Count non-OKAY B/R responses, sticking at all-ones.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_count <= '0;
        end else if (((b_hs && (bresp != RESP_OKAY)) || (r_hs && (rresp != RESP_OKAY)))
                     && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Purpose : randomized scoreboard bench for axi_lite_master against a BFM register slave.
// Latency : checks 3-cycle accept->rsp and 4-cycle back-to-back command spacing.
// Backpr. : BFM delays AW/W/B/R; bench withholds rsp_ready.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;

    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_write;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
`ifdef AXIL_MST_ERR_CNT_EN
    logic [15:0]       err_count;
`endif

    axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef AXIL_MST_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 aclk = ~aclk;

    int unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int unsigned acc_cyc;
        bit          lat_chk;
        int unsigned err;
    } exp_t;

    exp_t        sbq[$];
    logic [3:0]  addrq[$];
    logic [31:0] ref_mem [4];
    int unsigned exp_err = 0;
    int unsigned last_acc = 0;

    // ---------------- BFM slave configuration/state ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0, rsp_dly = 0;
    logic [1:0]  force_resp = RESP_OKAY;
    logic [31:0] slv_mem [4];
    bit          aw_got, w_got, ar_got, b_pend, r_pend;
    bit          aw_prev_hs, w_prev_hs, ar_prev_hs, aw_wait, w_wait;
    int          aw_cnt, w_cnt, b_cnt, r_cnt, aw_hs_n, w_hs_n;
    logic [3:0]  aw_a, ar_a, aw_prev_a, w_s, w_prev_s;
    logic [31:0] w_d, w_prev_d;

    // Register-file slave: 4 words at addr[3:2], byte strobes, programmable wait states.
    always @(negedge aclk) begin
        if (!aresetn) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
            aw_prev_hs = 0; w_prev_hs = 0; ar_prev_hs = 0; aw_wait = 0; w_wait = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0; aw_hs_n = 0; w_hs_n = 0;
        end else begin
            if (aw_prev_hs) chk("awvalid_drop", 64'(awvalid), 64'(0));
            if (w_prev_hs)  chk("wvalid_drop", 64'(wvalid), 64'(0));
            if (ar_prev_hs) chk("arvalid_drop", 64'(arvalid), 64'(0));
            if (aw_wait) chk("aw_stable", 64'({awvalid, awaddr}), 64'({1'b1, aw_prev_a}));
            if (w_wait)  chk("w_stable", 64'({wvalid, wstrb, wdata}), 64'({1'b1, w_prev_s, w_prev_d}));
            if (b_pend) bvalid = 0;
            if (r_pend) rvalid = 0;
            if (aw_got && w_got && !bvalid) begin
                chk("bready_wait", 64'(bready), 64'(1));
                if (b_cnt < b_dly) b_cnt++;
                else begin
                    chk("aw_hs_count", 64'(aw_hs_n), 64'(1));
                    chk("w_hs_count", 64'(w_hs_n), 64'(1));
                    for (int i = 0; i < 4; i++)
                        if (w_s[i]) slv_mem[aw_a[3:2]][8*i +: 8] = w_d[8*i +: 8];
                    bvalid = 1; bresp = force_resp;
                    aw_got = 0; w_got = 0; b_cnt = 0; aw_hs_n = 0; w_hs_n = 0;
                end
            end
            if (ar_got && !rvalid) begin
                chk("rready_wait", 64'(rready), 64'(1));
                if (r_cnt < r_dly) r_cnt++;
                else begin
                    rvalid = 1; rdata = slv_mem[ar_a[3:2]]; rresp = force_resp;
                    ar_got = 0; r_cnt = 0;
                end
            end
            b_pend = bvalid && bready;
            r_pend = rvalid && rready;
            // AW channel
            aw_prev_hs = 0; aw_wait = 0; awready = 0;
            if (awvalid) begin
                if (aw_cnt < aw_dly) begin
                    aw_cnt++; aw_wait = 1; aw_prev_a = awaddr;
                end else begin
                    awready = 1; aw_cnt = 0; aw_got = 1; aw_a = awaddr; aw_hs_n++; aw_prev_hs = 1;
                    if (addrq.size() == 0) chk("aw_unexpected", 64'(awvalid), 64'(0));
                    else chk("awaddr", 64'(awaddr), 64'(addrq.pop_front()));
                end
            end
            // W channel
            w_prev_hs = 0; w_wait = 0; wready = 0;
            if (wvalid) begin
                if (w_cnt < w_dly) begin
                    w_cnt++; w_wait = 1; w_prev_d = wdata; w_prev_s = wstrb;
                end else begin
                    wready = 1; w_cnt = 0; w_got = 1; w_d = wdata; w_s = wstrb; w_hs_n++; w_prev_hs = 1;
                end
            end
            // AR channel: always immediately ready
            ar_prev_hs = 0; arready = 0;
            if (arvalid) begin
                arready = 1; ar_got = 1; ar_a = araddr; ar_prev_hs = 1;
                if (addrq.size() == 0) chk("ar_unexpected", 64'(arvalid), 64'(0));
                else chk("araddr", 64'(araddr), 64'(addrq.pop_front()));
            end
        end
    end

    // ---------------- response monitor ----------------
    int unsigned hold_cnt = 0, first_cyc = 0;
    bit          in_rsp = 0, post_hs = 0;
    logic [34:0] cap;

    // Pops the scoreboard on every rsp handshake; checks hold/stability rules meanwhile.
    always @(negedge aclk) begin
        if (!aresetn) begin
            rsp_ready = 0; hold_cnt = 0; in_rsp = 0; post_hs = 0;
        end else begin
            if (post_hs) begin
                chk("cmd_ready_after_rsp", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
                post_hs = 0;
            end
            rsp_ready = 0;
            if (rsp_valid) begin
                chk("cmd_ready_in_rsp", 64'(cmd_ready), 64'(0));
                if (!in_rsp) begin
                    in_rsp = 1; first_cyc = cyc; cap = {rsp_write, rsp_resp, rsp_rdata};
                end else begin
                    chk("rsp_stable", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(cap));
                end
                if (hold_cnt < rsp_dly) hold_cnt++;
                else begin
                    exp_t e;
                    rsp_ready = 1; hold_cnt = 0; in_rsp = 0; post_hs = 1;
                    if (sbq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                    else begin
                        e = sbq.pop_front();
                        chk("rsp_write", 64'(rsp_write), 64'(e.wr));
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                        if (e.lat_chk) chk("latency", 64'(first_cyc - e.acc_cyc), 64'(3));
`ifdef AXIL_MST_ERR_CNT_EN
                        chk("err_count", 64'(err_count), 64'(e.err));
`endif
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] resp);
        exp_t e;
        int   n = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
            cmd_valid = 0;
            return;
        end
        force_resp = resp;
        e.wr = wr; e.resp = resp; e.acc_cyc = cyc;
        e.lat_chk = (aw_dly == 0) && (w_dly == 0) && (b_dly == 0) && (r_dly == 0);
        if (wr) begin
            e.rdata = 32'h0;
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[a[3:2]][8*i +: 8] = d[8*i +: 8];
        end else begin
            e.rdata = ref_mem[a[3:2]];
        end
        if (resp != RESP_OKAY) exp_err++;
        e.err = exp_err;
        sbq.push_back(e);
        addrq.push_back(a);
        last_acc = cyc;
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'(0));
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned first_acc;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; awready = 0; wready = 0; arready = 0;
        bvalid = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = 0;
        for (int i = 0; i < 4; i++) begin ref_mem[i] = 0; slv_mem[i] = 0; end

        aresetn = 0;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'(0));
        chk("rst_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(0));
        chk("rst_addr", 64'({awaddr, araddr, wstrb}), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("prot", 64'({awprot, arprot}), 64'(0));
`ifdef AXIL_MST_ERR_CNT_EN
        chk("rst_err_count", 64'(err_count), 64'(0));
`endif
        aresetn = 1;
        @(negedge aclk);

        // write/read basics and all four registers
        issue(1, 4'h4, 32'hDEADBEEF, 4'hF, RESP_OKAY);
        issue(0, 4'h4, 32'h0, 4'h0, RESP_OKAY);
        for (int i = 0; i < 4; i++) issue(1, 4'(i * 4), 32'hA5000000 + 32'(i * 32'h00110011), 4'hF, RESP_OKAY);
        for (int i = 0; i < 4; i++) issue(0, 4'(i * 4), 32'h0, 4'h0, RESP_OKAY);
        drain();

        // AW/W ordering: AW late, W late, then together
        aw_dly = 3; issue(1, 4'h8, 32'h11112222, 4'hF, RESP_OKAY); drain();
        aw_dly = 0; w_dly = 3; issue(1, 4'hC, 32'h33334444, 4'h3, RESP_OKAY); drain();
        w_dly = 0; issue(1, 4'h0, 32'h55556666, 4'hC, RESP_OKAY);
        issue(0, 4'h8, 32'h0, 4'h0, RESP_OKAY); issue(0, 4'hC, 32'h0, 4'h0, RESP_OKAY);
        issue(0, 4'h0, 32'h0, 4'h0, RESP_OKAY); drain();

        // backpressure on B, R and rsp
        b_dly = 5; r_dly = 5; rsp_dly = 4;
        issue(1, 4'h8, 32'hCAFEF00D, 4'hF, RESP_OKAY);
        issue(0, 4'h8, 32'h0, 4'h0, RESP_OKAY); drain();
        b_dly = 0; r_dly = 0; rsp_dly = 0;

        // error forwarding
        issue(0, 4'hC, 32'h0, 4'h0, RESP_SLVERR);
        issue(1, 4'h4, 32'h77778888, 4'h5, RESP_DECERR);
        issue(0, 4'h4, 32'h0, 4'h0, RESP_OKAY); drain();

        // reset while awvalid is waiting
        aw_dly = 6;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h0; cmd_wdata = 32'hBAD0BAD0; cmd_wstrb = 4'hF;
        begin
            int n = 0;
            while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
        end
        @(negedge aclk);
        cmd_valid = 0;
        @(negedge aclk);
        chk("pre_reset_awvalid", 64'(awvalid), 64'(1));
        aresetn = 0;
        @(negedge aclk);
        chk("mid_rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'(0));
        chk("mid_rst_idle", 64'(cmd_ready), 64'(1));
        @(negedge aclk);
        aresetn = 1;
        aw_dly = 0;
        @(negedge aclk);
        issue(0, 4'h0, 32'h0, 4'h0, RESP_OKAY); drain();

        // back-to-back random traffic
        issue(1'($urandom), 4'($urandom), $urandom, 4'($urandom), RESP_OKAY);
        first_acc = last_acc;
        for (int k = 1; k < 100; k++) begin
            logic [1:0] r;
            r = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 1)) : RESP_OKAY;
            issue(1'($urandom), 4'($urandom), $urandom, 4'($urandom), r);
        end
        chk("throughput_cycles", 64'(last_acc - first_acc), 64'(99 * 4));
        drain();
        chk("addrq_empty", 64'(addrq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
